// File: rtl/rob_pkg.sv
// Shared types and widths for the reorder buffer and its commit selector.
package rob_pkg;
  localparam int COMMIT_WIDTH = 3;
  localparam int ALLOC_WIDTH  = 3;
  localparam int RD_ARCH_W    = 5;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic [RD_ARCH_W-1:0] rd_arch;
    logic                 rd_we;
    logic                 ls;
  } rob_entry_t;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction
endpackage

// File: rtl/rob_commit_select.sv
// Picks the in-order prefix of retiring head entries, allowing at most one load/store per cycle.
module rob_commit_select
  import rob_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic [COMMIT_WIDTH-1:0] i_head_ready,
  input  logic [COMMIT_WIDTH-1:0] i_head_ls,
  input  logic [CNT_W-1:0]        i_count,
  output logic [COMMIT_WIDTH-1:0] o_commit_valid,
  output logic                    o_lsq_commit
);
  logic w_ok;
  logic w_ls_seen;

  // Any blocked slot stops the walk so the result stays a thermometer.
  always_comb begin
    o_commit_valid = '0;
    w_ok           = 1'b1;
    w_ls_seen      = 1'b0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (w_ok && (i_count > CNT_W'(k)) && i_head_ready[k] && !(w_ls_seen && i_head_ls[k])) begin
        o_commit_valid[k] = 1'b1;
        w_ls_seen         = w_ls_seen | i_head_ls[k];
      end else begin
        w_ok = 1'b0;
      end
    end
    o_lsq_commit = |(o_commit_valid & i_head_ls);
  end
endmodule

// File: rtl/reorder_buffer_commit.sv
// In-order retirement ROB: 3-wide allocate, 3 writeback ports, 3-wide commit with one load/store per cycle.
module reorder_buffer_commit
  import rob_pkg::*;
#(
  parameter int DEPTH           = 32,
  parameter int ARCH_ADDR_WIDTH = RD_ARCH_W,
  parameter int IDX_WIDTH       = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [2:0]                 alloc_valid,
  input  logic [ARCH_ADDR_WIDTH-1:0] alloc_rd_arch_0,
  input  logic [ARCH_ADDR_WIDTH-1:0] alloc_rd_arch_1,
  input  logic [ARCH_ADDR_WIDTH-1:0] alloc_rd_arch_2,
  input  logic                       alloc_rd_we_0,
  input  logic                       alloc_rd_we_1,
  input  logic                       alloc_rd_we_2,
  input  logic                       alloc_ls_0,
  input  logic                       alloc_ls_1,
  input  logic                       alloc_ls_2,
  output logic [2:0]                 alloc_ready,
  output logic [IDX_WIDTH-1:0]       alloc_idx_0,
  output logic [IDX_WIDTH-1:0]       alloc_idx_1,
  output logic [IDX_WIDTH-1:0]       alloc_idx_2,
  input  logic [2:0]                 wb_valid,
  input  logic [IDX_WIDTH-1:0]       wb_idx_0,
  input  logic [IDX_WIDTH-1:0]       wb_idx_1,
  input  logic [IDX_WIDTH-1:0]       wb_idx_2,
  output logic [2:0]                 commit_valid,
  output logic [ARCH_ADDR_WIDTH-1:0] commit_addr_0,
  output logic [ARCH_ADDR_WIDTH-1:0] commit_addr_1,
  output logic [ARCH_ADDR_WIDTH-1:0] commit_addr_2,
  output logic [IDX_WIDTH-1:0]       commit_rob_idx_0,
  output logic [IDX_WIDTH-1:0]       commit_rob_idx_1,
  output logic [IDX_WIDTH-1:0]       commit_rob_idx_2,
  output logic                       lsq_commit,
  output logic [IDX_WIDTH:0]         rob_count
);
  localparam int CNT_W = IDX_WIDTH + 1;

  rob_entry_t           r_entries [DEPTH];
  logic [IDX_WIDTH-1:0] r_head;
  logic [IDX_WIDTH-1:0] r_tail;
  logic [CNT_W-1:0]     r_count;

  logic [CNT_W-1:0]           w_free;
  logic [2:0]                 w_grant;
  logic [1:0]                 w_n_grant;
  logic [1:0]                 w_n_commit;
  logic [ARCH_ADDR_WIDTH-1:0] w_alloc_arch [ALLOC_WIDTH];
  logic [ALLOC_WIDTH-1:0]     w_alloc_we;
  logic [ALLOC_WIDTH-1:0]     w_alloc_ls;
  logic [IDX_WIDTH-1:0]       w_alloc_idx  [ALLOC_WIDTH];
  logic [IDX_WIDTH-1:0]       w_wb_idx     [3];
  logic [IDX_WIDTH-1:0]       w_head_idx   [COMMIT_WIDTH];
  rob_entry_t                 w_head_entry [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0]    w_head_ready;
  logic [COMMIT_WIDTH-1:0]    w_head_ls;
  logic [ARCH_ADDR_WIDTH-1:0] w_commit_addr [COMMIT_WIDTH];
  logic [IDX_WIDTH-1:0]       w_commit_idx  [COMMIT_WIDTH];

  assign w_alloc_arch = '{alloc_rd_arch_0, alloc_rd_arch_1, alloc_rd_arch_2};
  assign w_alloc_we   = {alloc_rd_we_2, alloc_rd_we_1, alloc_rd_we_0};
  assign w_alloc_ls   = {alloc_ls_2, alloc_ls_1, alloc_ls_0};
  assign w_wb_idx     = '{wb_idx_0, wb_idx_1, wb_idx_2};

  // Space is judged from the registered count only, so a freed entry is never reused on the same edge.
  assign w_free      = CNT_W'(DEPTH) - r_count;
  assign alloc_ready = (w_free >= CNT_W'(3)) ? 3'b111 :
                       (w_free == CNT_W'(2)) ? 3'b011 :
                       (w_free == CNT_W'(1)) ? 3'b001 : 3'b000;
  assign w_grant     = alloc_valid & alloc_ready;
  assign w_n_grant   = popcount3(w_grant);
  assign w_n_commit  = popcount3(commit_valid);

  generate
    for (genvar gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_slot
      assign w_alloc_idx[gi]   = r_tail + IDX_WIDTH'(gi);
      assign w_head_idx[gi]    = r_head + IDX_WIDTH'(gi);
      assign w_head_entry[gi]  = r_entries[w_head_idx[gi]];
      assign w_head_ready[gi]  = w_head_entry[gi].busy & w_head_entry[gi].done;
      assign w_head_ls[gi]     = w_head_entry[gi].ls;
      assign w_commit_addr[gi] = (commit_valid[gi] && w_head_entry[gi].rd_we) ? w_head_entry[gi].rd_arch : '0;
      assign w_commit_idx[gi]  = commit_valid[gi] ? w_head_idx[gi] : '0;
    end
  endgenerate

  rob_commit_select #(.CNT_W(CNT_W)) u_select (
    .i_head_ready   (w_head_ready),
    .i_head_ls      (w_head_ls),
    .i_count        (r_count),
    .o_commit_valid (commit_valid),
    .o_lsq_commit   (lsq_commit)
  );

  assign alloc_idx_0      = w_alloc_idx[0];
  assign alloc_idx_1      = w_alloc_idx[1];
  assign alloc_idx_2      = w_alloc_idx[2];
  assign commit_addr_0    = w_commit_addr[0];
  assign commit_addr_1    = w_commit_addr[1];
  assign commit_addr_2    = w_commit_addr[2];
  assign commit_rob_idx_0 = w_commit_idx[0];
  assign commit_rob_idx_1 = w_commit_idx[1];
  assign commit_rob_idx_2 = w_commit_idx[2];
  assign rob_count        = r_count;

  // Later assignments win: retirement clears a same-cycle writeback, allocation overwrites last.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i].busy <= 1'b0;
        r_entries[i].done <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (wb_valid[k] && r_entries[w_wb_idx[k]].busy) begin
          r_entries[w_wb_idx[k]].done <= 1'b1;
        end
      end
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (commit_valid[k]) begin
          r_entries[w_head_idx[k]].busy <= 1'b0;
          r_entries[w_head_idx[k]].done <= 1'b0;
        end
      end
      for (int k = 0; k < ALLOC_WIDTH; k++) begin
        if (w_grant[k]) begin
          r_entries[w_alloc_idx[k]] <= '{busy: 1'b1, done: 1'b0, rd_arch: w_alloc_arch[k],
                                         rd_we: w_alloc_we[k], ls: w_alloc_ls[k]};
        end
      end
      r_head  <= r_head + IDX_WIDTH'(w_n_commit);
      r_tail  <= r_tail + IDX_WIDTH'(w_n_grant);
      r_count <= r_count + CNT_W'(w_n_grant) - CNT_W'(w_n_commit);
    end
  end
endmodule
